// File: rtl/approx_add_pkg.sv
// Constants shared by the approximate adder core and its arbiter wrapper.
// Bit positions describe where the lower-part approximation ends.
package approx_add_pkg;

   localparam int unsigned APPROX_LSB      = 4;
   localparam int unsigned APPROX_CIN_BIT  = 3;
   localparam int unsigned APPROX_PASS_BIT = 3;

   // Round-robin successor of idx among n requesters.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/approx_add16se_core.sv
// Combinational signed adder with selectable exact or lower-part-approximate sum.
// Result is one bit wider than the operands, so neither mode can overflow.
module approx_add16se_core
   import approx_add_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         exact_i,
   output logic [W:0]   sum_o
);

   localparam int unsigned HW = W - APPROX_LSB;

   logic [W:0]  exact_sum;
   logic [W:0]  approx_sum;
   logic [HW:0] hi_sum;

   always_comb begin
      exact_sum = {a_i[W-1], a_i} + {b_i[W-1], b_i};
      // Upper field uses B's top discarded bit as a carry-in guess.
      hi_sum = {a_i[W-1], a_i[W-1:APPROX_LSB]}
             + {b_i[W-1], b_i[W-1:APPROX_LSB]}
             + {{HW{1'b0}}, b_i[APPROX_CIN_BIT]};
      approx_sum                  = '0;
      approx_sum[W:APPROX_LSB]    = hi_sum;
      approx_sum[APPROX_PASS_BIT] = a_i[APPROX_PASS_BIT];
      sum_o = exact_i ? exact_sum : approx_sum;
   end

endmodule

// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter sharing one approximate adder among N_REQ requesters,
// with a registered, id-tagged response slot and a saturating op counter.
module approx_add_arbiter
   import approx_add_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W     = 16,
   parameter int unsigned IDW   = 2,
   parameter int unsigned CNTW  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   input  logic [N_REQ-1:0]   req_exact,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [W:0]         rsp_sum,
   output logic [IDW-1:0]     rsp_id,
   output logic [CNTW-1:0]    op_count,
   input  logic               clr_count
);

   logic [IDW-1:0]   rr_q, rr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [W:0]       rsp_sum_q, rsp_sum_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;

   logic             slot_free;
   logic             grant_found;
   logic             accept;
   logic [IDW-1:0]   grant_idx;
   logic [IDW:0]     grant_sum;
   logic [N_REQ-1:0] valid_rot;
   logic [W-1:0]     a_sel, b_sel;
   logic             exact_sel;
   logic [W:0]       core_sum;

   assign slot_free = !rsp_valid_q || rsp_ready;

   // Rotate so bit 0 is the rr pointer; the first set bit is the winner.
   always_comb begin
      valid_rot   = N_REQ'({req_valid, req_valid} >> rr_q);
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_sum   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_found && valid_rot[k]) begin
            grant_found = 1'b1;
            grant_sum   = {1'b0, rr_q} + (IDW+1)'(k);
            if (grant_sum >= (IDW+1)'(N_REQ)) begin
               grant_sum = grant_sum - (IDW+1)'(N_REQ);
            end
            grant_idx = grant_sum[IDW-1:0];
         end
      end
   end

   assign accept = grant_found && slot_free && !rst;

   always_comb begin
      req_ready = '0;
      a_sel     = '0;
      b_sel     = '0;
      exact_sel = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            req_ready[i] = accept;
            a_sel        = req_a[i*W +: W];
            b_sel        = req_b[i*W +: W];
            exact_sel    = req_exact[i];
         end
      end
   end

   approx_add16se_core #(
      .W (W)
   ) u_core (
      .a_i     (a_sel),
      .b_i     (b_sel),
      .exact_i (exact_sel),
      .sum_o   (core_sum)
   );

   always_comb begin
      rr_d        = rr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_id_d    = rsp_id_q;
      cnt_d       = cnt_q;
      // A new accept overwrites a response being drained in the same cycle.
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_sum_d   = core_sum;
         rsp_id_d    = grant_idx;
         rr_d        = IDW'(rr_next(32'(grant_idx), N_REQ));
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if (clr_count) begin
         cnt_d = '0;
      end else if (accept && cnt_q != {CNTW{1'b1}}) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_id_q    <= '0;
         cnt_q       <= '0;
      end else begin
         rr_q        <= rr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_id_q    <= rsp_id_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_id    = rsp_id_q;
   assign op_count  = cnt_q;

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Randomized and directed bench for approx_add_arbiter against an arithmetic
// reference model of arbitration, response slot and counter.
module tb_approx_add_arbiter;

   localparam int N    = 4;
   localparam int W    = 16;
   localparam int IDW  = 2;
   localparam int CNTW = 4;
   localparam int CMAX = (1 << CNTW) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid, req_ready, req_exact;
   logic [N*W-1:0]   req_a, req_b;
   logic             rsp_valid, rsp_ready;
   logic [W:0]       rsp_sum;
   logic [IDW-1:0]   rsp_id;
   logic [CNTW-1:0]  op_count;
   logic             clr_count;

   int errors = 0;
   int checks = 0;

   bit         m_valid;
   logic [W:0] m_sum;
   int         m_id, m_rr, m_cnt;

   always #5 clk = ~clk;

   approx_add_arbiter #(
      .N_REQ (N),
      .W     (W),
      .IDW   (IDW),
      .CNTW  (CNTW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_exact (req_exact),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .op_count  (op_count),
      .clr_count (clr_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ex);
      int sa, sb, r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (ex) r = sa + sb;
      else r = ((sa >>> 4) + (sb >>> 4) + int'(b[3])) * 16 + int'(a[3]) * 8;
      return r[W:0];
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_sum   = '0;
      m_id    = 0;
      m_rr    = 0;
      m_cnt   = 0;
   endtask

   // One cycle: drive inputs, check grant, advance model, check registered outputs.
   task automatic step(input logic [N-1:0] v, input logic [N-1:0] ex,
                       input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                       input logic rdy, input logic clr);
      int g;
      logic [N-1:0] exp_ready;
      req_valid = v;
      req_exact = ex;
      req_a     = a;
      req_b     = b;
      rsp_ready = rdy;
      clr_count = clr;
      #1;
      g = -1;
      if (!m_valid || rdy) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (g < 0 && v[idx]) g = idx;
         end
      end
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      @(posedge clk);
      if (g >= 0) begin
         m_valid = 1'b1;
         m_sum   = ref_sum(a[g*W +: W], b[g*W +: W], ex[g]);
         m_id    = g;
         m_rr    = (g + 1) % N;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      if (clr) m_cnt = 0;
      else if (g >= 0 && m_cnt < CMAX) m_cnt++;
      #1;
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("op_count", 32'(op_count), 32'(m_cnt));
   endtask

   function automatic logic [W-1:0] rand_op();
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) return 16'h8000;
      if (r == 1) return 16'h7FFF;
      if (r == 2) return 16'hFFFF;
      return W'($urandom);
   endfunction

   initial begin
      logic [N*W-1:0] ra, rb;
      rst       = 1'b1;
      req_valid = '1;
      req_exact = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      clr_count = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_req_ready", 32'(req_ready), 32'h0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset_rsp_sum", 32'(rsp_sum), 32'h0);
      check("reset_rsp_id", 32'(rsp_id), 32'h0);
      check("reset_op_count", 32'(op_count), 32'h0);
      rst       = 1'b0;
      req_valid = '0;

      step(4'b0001, 4'b0000, {N{16'd100}}, {N{16'd27}}, 1'b1, 1'b0);
      check("approx_100_27", 32'(rsp_sum), 32'd128);
      check("approx_id0", 32'(rsp_id), 32'd0);
      step(4'b0001, 4'b0001, {N{16'd100}}, {N{16'd27}}, 1'b1, 1'b0);
      check("exact_100_27", 32'(rsp_sum), 32'd127);
      step(4'b0001, 4'b1111, {N{16'h8000}}, {N{16'h8000}}, 1'b1, 1'b0);
      check("exact_min_min", 32'(rsp_sum), 32'h10000);
      step(4'b0001, 4'b1111, {N{16'h7FFF}}, {N{16'h7FFF}}, 1'b1, 1'b0);
      check("exact_max_max", 32'(rsp_sum), 32'd65534);

      // Backpressure: hold response from requester 1, then drain and replace with 2.
      step(4'b0010, 4'b0000, {N{16'h1234}}, {N{16'h0F0F}}, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(4'b0110, 4'b0110, {N{16'h2222}}, {N{16'h1111}}, 1'b0, 1'b0);
         check("bp_hold_id", 32'(rsp_id), 32'd1);
      end
      step(4'b0110, 4'b0110, {N{16'h2222}}, {N{16'h1111}}, 1'b1, 1'b0);
      check("bp_replace_id", 32'(rsp_id), 32'd2);
      check("bp_replace_valid", 32'(rsp_valid), 32'd1);

      // Asynchronous reset pulse between edges while a response is held.
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(rsp_valid), 32'h0);
      check("async_rst_count", 32'(op_count), 32'h0);
      check("async_rst_sum", 32'(rsp_sum), 32'h0);
      #1 rst = 1'b0;
      model_reset();

      for (int k = 0; k < 8; k++) begin
         step(4'b1111, 4'b0101, {N{16'h0ABC}}, {N{16'hF00D}}, 1'b1, 1'b0);
         check("rr_order", 32'(rsp_id), 32'(k % N));
      end

      step(4'b0000, 4'b0000, '0, '0, 1'b1, 1'b1);
      for (int k = 0; k < 17; k++) begin
         step(4'b1111, 4'b0000, {N{16'h0001}}, {N{16'h0002}}, 1'b1, 1'b0);
      end
      check("count_saturated", 32'(op_count), 32'd15);
      step(4'b1111, 4'b0000, {N{16'h0001}}, {N{16'h0002}}, 1'b1, 1'b1);
      check("count_clr_priority", 32'(op_count), 32'd0);

      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            ra[i*W +: W] = rand_op();
            rb[i*W +: W] = rand_op();
         end
         step(N'($urandom), N'($urandom), ra, rb, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 31) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
